// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: queues bytes in a small FIFO and serializes each
// as start, 8 data bits LSB first, odd parity and stop on emulated clock/data lines.
// A host inhibit during a data phase aborts the frame, which is retried after the gap.
module ps2_device_tx #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned PS2_FREQ   = 12500,
    parameter int unsigned GAP_CYCLES = 2000,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          host_inhibit,
    output logic                          ps2_clock_out,
    output logic                          ps2_data_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          retry_pulse
);

    localparam int unsigned HALF     = CLK_FREQ / (2 * PS2_FREQ);
    localparam int unsigned PHASE_W  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned FRAME_W  = 11;

    localparam logic [IDX_W-1:0]   STOP_IDX   = IDX_W'(FRAME_W - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(HALF - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_HI = 2'd1,
        SHIFT_LO = 2'd2,
        GAP      = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [7:0]           mem [FIFO_DEPTH];
    logic [7:0]           head;
    logic [CNT_W-1:0]     count_d;
    logic                 push;
    logic                 pop;
    logic                 clk_line_d;
    logic                 data_line_d;
    logic                 busy_d;
    logic                 retry_d;

    assign push = tx_valid & tx_ready;
    assign head = mem[rd_ptr_q];

    // FIFO storage; contents need no reset since occupancy is tracked by fifo_count
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

    // Occupancy update; a full FIFO never accepts, so no overflow case exists
    always_comb begin
        count_d = fifo_count;
        if (push && !pop) begin
            count_d = fifo_count + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = fifo_count - CNT_W'(1);
        end
    end

    // Next-state, datapath and registered-output values
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        gap_d   = gap_q;
        frame_d = frame_q;
        pop     = 1'b0;
        retry_d = 1'b0;

        case (state_q)
            IDLE: begin
                if ((fifo_count != '0) && !host_inhibit) begin
                    frame_d = {1'b1, ~^head, head, 1'b0};
                    idx_d   = '0;
                    phase_d = '0;
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (host_inhibit && (idx_q != STOP_IDX)) begin
                    retry_d = 1'b1;
                    gap_d   = '0;
                    phase_d = '0;
                    state_d = GAP;
                end else if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    state_d = SHIFT_LO;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            SHIFT_LO: begin
                if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    if (idx_q == STOP_IDX) begin
                        pop     = 1'b1;
                        gap_d   = '0;
                        state_d = GAP;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = SHIFT_HI;
                    end
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            GAP: begin
                if (host_inhibit) begin
                    gap_d = '0;
                end else if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = GAP;
                gap_d   = '0;
            end
        endcase

        // Line values follow the next state so each phase drives from its first cycle
        busy_d      = (state_d == SHIFT_HI) || (state_d == SHIFT_LO);
        clk_line_d  = (state_d != SHIFT_LO);
        data_line_d = busy_d ? frame_d[idx_d] : 1'b1;
    end

    // State, datapath and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= GAP;
            idx_q         <= '0;
            phase_q       <= '0;
            gap_q         <= '0;
            frame_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_count    <= '0;
            tx_ready      <= 1'b1;
            ps2_clock_out <= 1'b1;
            ps2_data_out  <= 1'b1;
            busy          <= 1'b0;
            retry_pulse   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            phase_q       <= phase_d;
            gap_q         <= gap_d;
            frame_q       <= frame_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            fifo_count    <= count_d;
            tx_ready      <= (count_d != CNT_FULL);
            ps2_clock_out <= clk_line_d;
            ps2_data_out  <= data_line_d;
            busy          <= busy_d;
            retry_pulse   <= retry_d;
        end
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx with HALF=4, GAP_CYCLES=8, FIFO_DEPTH=4.
module tb_ps2_device_tx;

    logic       clock;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       host_inhibit;
    logic       ps2_clock_out;
    logic       ps2_data_out;
    logic       busy;
    logic [2:0] fifo_count;
    logic       retry_pulse;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [10:0] frames_q [$];
    int          starts_q [$];
    int          ends_q   [$];

    ps2_device_tx #(
        .CLK_FREQ   (80),
        .PS2_FREQ   (10),
        .GAP_CYCLES (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .host_inhibit  (host_inhibit),
        .ps2_clock_out (ps2_clock_out),
        .ps2_data_out  (ps2_data_out),
        .busy          (busy),
        .fifo_count    (fifo_count),
        .retry_pulse   (retry_pulse)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Frame monitor: data sampled at each falling PS/2 clock, frame boundaries from busy
    initial begin : monitor
        logic [10:0] cur;
        int          nb;
        logic        prev_clk;
        logic        prev_busy;
        cur = '0; nb = 0; prev_clk = 1'b1; prev_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                nb = 0; prev_clk = 1'b1; prev_busy = 1'b0;
            end else begin
                if (prev_clk && !ps2_clock_out && nb < 11) begin
                    cur[4'(nb)] = ps2_data_out;
                    nb++;
                end
                if (!prev_busy && busy) starts_q.push_back(cyc);
                if (prev_busy && !busy) begin
                    ends_q.push_back(cyc);
                    if (nb == 11) frames_q.push_back(cur);
                    nb = 0;
                end
                prev_clk  = ps2_clock_out;
                prev_busy = busy;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int k = 0; k < 500 && !tx_ready; k++) tick();
        check("push_ready", 32'(tx_ready), 32'd1);
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_busy();
        for (int k = 0; k < 500 && !busy; k++) tick();
        check("busy_rise", 32'(busy), 32'd1);
    endtask

    task automatic wait_frames(input int n);
        for (int k = 0; k < 2000 && frames_q.size() < n; k++) tick();
        check("frames_seen", 32'(frames_q.size() >= n), 32'd1);
    endtask

    initial begin : stimulus
        logic [7:0] b3 [5];
        int n;
        int c;
        int n0;
        logic acc;
        logic seen;

        reset_n = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; host_inhibit = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_clk",   32'(ps2_clock_out), 32'd1);
        check("rst_data",  32'(ps2_data_out),  32'd1);
        check("rst_count", 32'(fifo_count),    32'd0);
        check("rst_ready", 32'(tx_ready),      32'd1);
        check("rst_busy",  32'(busy),          32'd0);
        check("rst_retry", 32'(retry_pulse),   32'd0);
        reset_n = 1'b1;

        // 1: single byte 0x1C
        push_byte(8'h1C);
        check("t1_count_push", 32'(fifo_count), 32'd1);
        wait_busy();
        check("t1_count_start", 32'(fifo_count), 32'd1);
        check("t1_start_bit", 32'(ps2_data_out), 32'd0);
        repeat (87) tick();
        check("t1_stop_lo_clk",  32'(ps2_clock_out), 32'd0);
        check("t1_stop_lo_data", 32'(ps2_data_out),  32'd1);
        check("t1_stop_lo_cnt",  32'(fifo_count),    32'd1);
        tick();
        check("t1_end_busy", 32'(busy),          32'd0);
        check("t1_end_cnt",  32'(fifo_count),    32'd0);
        check("t1_end_clk",  32'(ps2_clock_out), 32'd1);
        check("t1_end_data", 32'(ps2_data_out),  32'd1);
        wait_frames(1);
        check("t1_frame", 32'(frames_q[0]), 32'(11'b1_0_00011100_0));
        check("t1_len",   32'(ends_q[0] - starts_q[0]), 32'd88);

        // 2: back-to-back 0xF0, 0x00
        tx_data = 8'hF0; tx_valid = 1'b1; tick();
        tx_data = 8'h00; tick();
        tx_valid = 1'b0;
        check("t2_count", 32'(fifo_count), 32'd2);
        wait_frames(3);
        check("t2_frame_f0", 32'(frames_q[1]), 32'(11'b1_1_11110000_0));
        check("t2_frame_00", 32'(frames_q[2]), 32'(11'b1_1_00000000_0));
        check("t2_gap", 32'(starts_q[2] - ends_q[1]), 32'd9);

        // 3: five bytes with tx_valid held against a depth-4 FIFO
        b3[0] = 8'hA1; b3[1] = 8'hB2; b3[2] = 8'hC3; b3[3] = 8'hD4; b3[4] = 8'hE5;
        n = 0; seen = 1'b0;
        tx_valid = 1'b1;
        for (int k = 0; k < 400 && n < 5; k++) begin
            tx_data = b3[n];
            acc = tx_ready;
            tick();
            if (acc) begin
                n++;
                if (n == 4) begin
                    check("t3_full_ready", 32'(tx_ready),   32'd0);
                    check("t3_full_count", 32'(fifo_count), 32'd4);
                end
            end
            if (n == 4 && tx_ready && !seen) begin
                seen = 1'b1;
                check("t3_reopen_count", 32'(fifo_count), 32'd3);
                check("t3_reopen_busy",  32'(busy),       32'd0);
            end
        end
        tx_valid = 1'b0;
        check("t3_all_accepted", 32'(n), 32'd5);
        wait_frames(8);
        check("t3_frame_a1", 32'(frames_q[3]), 32'(11'b1_0_10100001_0));
        check("t3_frame_b2", 32'(frames_q[4]), 32'(11'b1_1_10110010_0));
        check("t3_frame_c3", 32'(frames_q[5]), 32'(11'b1_1_11000011_0));
        check("t3_frame_d4", 32'(frames_q[6]), 32'(11'b1_1_11010100_0));
        check("t3_frame_e5", 32'(frames_q[7]), 32'(11'b1_0_11100101_0));

        // 4: inhibit during data bit 4 high phase aborts and retries 0x25
        push_byte(8'h25);
        wait_busy();
        repeat (40) tick();
        check("t4_d4_clk",  32'(ps2_clock_out), 32'd1);
        check("t4_d4_data", 32'(ps2_data_out),  32'd0);
        host_inhibit = 1'b1;
        tick();
        check("t4_abort_clk",   32'(ps2_clock_out), 32'd1);
        check("t4_abort_data",  32'(ps2_data_out),  32'd1);
        check("t4_abort_retry", 32'(retry_pulse),   32'd1);
        check("t4_abort_busy",  32'(busy),          32'd0);
        check("t4_abort_count", 32'(fifo_count),    32'd1);
        tick();
        check("t4_retry_once", 32'(retry_pulse), 32'd0);
        tick();
        host_inhibit = 1'b0;
        c  = cyc;
        n0 = starts_q.size();
        wait_frames(9);
        check("t4_restart_delay", 32'(starts_q[n0] - c), 32'd9);
        check("t4_frame_25", 32'(frames_q[8]), 32'(11'b1_0_00100101_0));
        check("t4_count_end", 32'(fifo_count), 32'd0);

        // 5: inhibit during stop-bit high phase is ignored; gap waits for release
        push_byte(8'h33);
        wait_busy();
        repeat (80) tick();
        host_inhibit = 1'b1;
        tick();
        check("t5_stop_busy",  32'(busy),        32'd1);
        check("t5_stop_retry", 32'(retry_pulse), 32'd0);
        check("t5_stop_data",  32'(ps2_data_out), 32'd1);
        repeat (3) tick();
        check("t5_stop_lo_clk", 32'(ps2_clock_out), 32'd0);
        repeat (4) tick();
        check("t5_end_busy",  32'(busy),       32'd0);
        check("t5_end_count", 32'(fifo_count), 32'd0);
        push_byte(8'h81);
        repeat (15) tick();
        check("t5_held_busy", 32'(busy), 32'd0);
        n0 = starts_q.size();
        host_inhibit = 1'b0;
        c = cyc;
        wait_frames(11);
        check("t5_frame_33", 32'(frames_q[9]),  32'(11'b1_1_00110011_0));
        check("t5_frame_81", 32'(frames_q[10]), 32'(11'b1_1_10000001_0));
        check("t5_release_delay", 32'(starts_q[n0] - c), 32'd9);

        // 6: asynchronous reset mid-frame with three bytes queued
        tx_valid = 1'b1;
        tx_data = 8'h11; tick();
        tx_data = 8'h22; tick();
        tx_data = 8'h33; tick();
        tx_valid = 1'b0;
        check("t6_count_q", 32'(fifo_count), 32'd3);
        wait_busy();
        repeat (4) tick();
        check("t6_pre_clk", 32'(ps2_clock_out), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_clk",   32'(ps2_clock_out), 32'd1);
        check("t6_rst_data",  32'(ps2_data_out),  32'd1);
        check("t6_rst_count", 32'(fifo_count),    32'd0);
        check("t6_rst_ready", 32'(tx_ready),      32'd1);
        check("t6_rst_busy",  32'(busy),          32'd0);
        tick(); tick();
        reset_n = 1'b1;
        n0 = starts_q.size();
        repeat (30) tick();
        check("t6_no_start", 32'(starts_q.size() - n0), 32'd0);
        check("t6_idle_count", 32'(fifo_count), 32'd0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tx_data = 8'h7E; tx_valid = 1'b1;
        c = cyc;
        tick();
        tx_valid = 1'b0;
        check("t6_push_count", 32'(fifo_count), 32'd1);
        wait_frames(12);
        check("t6_first_delay", 32'(starts_q[n0] - c), 32'd9);
        check("t6_frame_7e", 32'(frames_q[11]), 32'(11'b1_1_01111110_0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
